mem_port_arbiter: RTL and testbench

- Shares the single-ported unified byte memory between the instruction-fetch requester (I) and the load/store requester (D).
- The memory reads combinationally and writes on the clock edge; the arbiter serialises both requesters onto that one port.
- Drives the memory's read, write, func3, addr and data_in inputs, and returns a registered response to each requester.
- The core stalls on a pending request until its ack pulses.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_range_check.sv | 26 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
// Func3 encodings match the memory's byte/half/word (signed and unsigned) decoding.
package mem_port_arbiter_pkg;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StResp  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_e;

  // Bytes touched by an access; 0 marks an undefined func3.
  function automatic logic [2:0] access_size(input logic [2:0] func3);
    logic [2:0] size;
    case (func3)
      F3_BYTE, F3_BYTEU: size = 3'd1;
      F3_HALF, F3_HALFU: size = 3'd2;
      F3_WORD:           size = 3'd4;
      default:           size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the I/D memory port arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_we, d_func3, d_addr, d_wdata,
    output d_ack, d_rdata, d_err,
    output mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_we, d_func3, d_addr, d_wdata,
    input  d_ack, d_rdata, d_err,
    input  mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_range_check.sv
// Flags accesses that run past the implemented memory or use an undefined func3.
// The end address is formed one bit wider than the address so it cannot wrap.
module mem_range_check
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        func3_i,
  output logic              err_o
);

  localparam int unsigned       LimW  = ADDR_W + 1;
  localparam logic [ADDR_W:0]   Limit = LimW'(MEM_BYTES);

  logic [2:0]      size;
  logic [ADDR_W:0] end_addr;

  always_comb begin
    size     = access_size(func3_i);
    end_addr = {1'b0, addr_i} + {{(ADDR_W - 2){1'b0}}, size};
    err_o    = (size == 3'd0) || (end_addr > Limit);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch (I) and load/store (D) onto the single memory port.
// Define ARB_ROUND_ROBIN_EN to break ties in favour of the requester not served last.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic              own_d;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_f3;
  logic              acc_we;
  logic              acc_err;
  logic              issue;
  owner_e            idle_pick;

  // The access presented to memory always follows the current owner.
  always_comb begin
    own_d    = (owner_q == OwnD);
    acc_addr = own_d ? bus.d_addr : bus.i_addr;
    acc_f3   = own_d ? bus.d_func3 : F3_WORD;
    acc_we   = own_d & bus.d_we;
  end

  mem_range_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_range_check (
    .addr_i  (acc_addr),
    .func3_i (acc_f3),
    .err_o   (acc_err)
  );

  // Reset overrides the strobes so an access caught mid-SERVE never commits.
  assign issue         = (state_q == StServe) & ~acc_err & ~rst;
  assign bus.mem_read  = issue & ~acc_we;
  assign bus.mem_write = issue & acc_we;
  assign bus.mem_func3 = acc_f3;
  assign bus.mem_addr  = acc_addr;
  assign bus.mem_wdata = bus.d_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  always_comb begin
    if (bus.i_req && bus.d_req) begin
      idle_pick = (last_q == OwnD) ? OwnI : OwnD;
    end else begin
      idle_pick = bus.d_req ? OwnD : OwnI;
    end
    last_d = (state_q == StServe) ? owner_q : last_q;
  end
`else
  assign idle_pick = bus.d_req ? OwnD : OwnI;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_err_d   = i_err_q;
    d_err_d   = d_err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          owner_d = idle_pick;
          state_d = StServe;
        end
      end
      StServe: begin
        state_d = StResp;
        if (own_d) begin
          d_ack_d   = 1'b1;
          d_err_d   = acc_err;
          d_rdata_d = (acc_err || acc_we) ? 32'd0 : bus.mem_rdata;
        end else begin
          i_ack_d   = 1'b1;
          i_err_d   = acc_err;
          i_rdata_d = acc_err ? 32'd0 : bus.mem_rdata;
        end
      end
      StResp: begin
        // Only the other requester may follow; the one just acked is masked.
        if (own_d ? bus.i_req : bus.d_req) begin
          owner_d = own_d ? OwnI : OwnD;
          state_d = StServe;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnI;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= OwnD;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model and an ack scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned MB = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .MEM_BYTES (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: combinational read with extension, clocked write, bench preload port.
  logic [7:0]  mem [MB];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;
  int          write_cnt = 0;
  logic [9:0]  a0, a1, a2, a3;
  logic [31:0] w;

  always_comb begin
    a0 = bus.mem_addr[9:0];
    a1 = a0 + 10'd1;
    a2 = a0 + 10'd2;
    a3 = a0 + 10'd3;
    w  = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (bus.mem_func3)
      F3_BYTE:  bus.mem_rdata = {{24{w[7]}}, w[7:0]};
      F3_HALF:  bus.mem_rdata = {{16{w[15]}}, w[15:0]};
      F3_WORD:  bus.mem_rdata = w;
      F3_BYTEU: bus.mem_rdata = {24'd0, w[7:0]};
      F3_HALFU: bus.mem_rdata = {16'd0, w[15:0]};
      default:  bus.mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_write === 1'b1) begin
      write_cnt <= write_cnt + 1;
      case (bus.mem_func3)
        F3_BYTE, F3_BYTEU: mem[a0] <= bus.mem_wdata[7:0];
        F3_HALF, F3_HALFU: begin
          mem[a0] <= bus.mem_wdata[7:0];
          mem[a1] <= bus.mem_wdata[15:8];
        end
        default: begin
          mem[a0] <= bus.mem_wdata[7:0];
          mem[a1] <= bus.mem_wdata[15:8];
          mem[a2] <= bus.mem_wdata[23:16];
          mem[a3] <= bus.mem_wdata[31:24];
        end
      endcase
    end
  end

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] addr, input logic [7:0] data);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic retire(input string tag);
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s.unexpected_ack: observed %0d queued expected >0", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".who"}, {31'd0, bus.d_ack}, {31'd0, e.is_d});
      check({tag, ".rdata"}, e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
      check({tag, ".err"}, {31'd0, e.is_d ? bus.d_err : bus.i_err}, {31'd0, e.err});
    end
  endtask

  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(bus.i_ack === 1'b1 || bus.d_ack === 1'b1) && lat < 20);
    if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) retire(tag);
    else check({tag, ".ack_seen"}, {31'd0, bus.i_ack | bus.d_ack}, 32'd1);
  endtask

  task automatic d_op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    bus.d_we    = we;
    bus.d_func3 = f3;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    sb.push_back('{1'b1, exp_rd, exp_err});
    wait_ack(tag, lat);
    check({tag, ".lat"}, lat, 32'd2);
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic i_op(input string tag, input logic [AW-1:0] addr,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    bus.i_addr = addr;
    bus.i_req  = 1'b1;
    sb.push_back('{1'b0, exp_rd, exp_err});
    wait_ack(tag, lat);
    check({tag, ".lat"}, lat, 32'd2);
    bus.i_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wc;
    int lat;
    bit first_d;

    rst         = 1'b1;
    pl_en       = 1'b0;
    pl_addr     = '0;
    pl_data     = '0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_func3 = F3_WORD;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    tick();
    tick();
    poke(10'h010, 8'h93); poke(10'h011, 8'h00); poke(10'h012, 8'h50); poke(10'h013, 8'h00);
    poke(10'h3FC, 8'h11); poke(10'h3FD, 8'h22); poke(10'h3FE, 8'hA5); poke(10'h3FF, 8'h5A);
    poke(10'h200, 8'h33);

    // Reset state
    check("rst.i_ack", {31'd0, bus.i_ack}, 32'd0);
    check("rst.d_ack", {31'd0, bus.d_ack}, 32'd0);
    check("rst.i_rdata", bus.i_rdata, 32'd0);
    check("rst.d_rdata", bus.d_rdata, 32'd0);
    check("rst.mem_read", {31'd0, bus.mem_read}, 32'd0);
    check("rst.mem_write", {31'd0, bus.mem_write}, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch only
    wc = write_cnt;
    i_op("fetch", 12'h010, 32'h00500093, 1'b0);
    check("fetch.no_write", write_cnt - wc, 32'd0);

    // Store half then load signed and unsigned
    d_op("st_h", 1'b1, F3_HALF, 12'h1F4, 32'hFFFF8001, 32'd0, 1'b0);
    check("st_h.byte0", {24'd0, mem[10'h1F4]}, 32'h01);
    check("st_h.byte1", {24'd0, mem[10'h1F5]}, 32'h80);
    d_op("ld_h", 1'b0, F3_HALF, 12'h1F4, 32'd0, 32'hFFFF8001, 1'b0);
    d_op("ld_hu", 1'b0, F3_HALFU, 12'h1F4, 32'd0, 32'h00008001, 1'b0);

    // Contention: both rise together, back-to-back service without an IDLE bubble
    poke(10'h1F4, 8'd17);
    first_d = !RrEn;
    bus.d_we    = 1'b0;
    bus.d_func3 = F3_BYTEU;
    bus.d_addr  = 12'h1F4;
    bus.i_addr  = 12'h010;
    if (first_d) begin
      sb.push_back('{1'b1, 32'd17, 1'b0});
      sb.push_back('{1'b0, 32'h00500093, 1'b0});
    end else begin
      sb.push_back('{1'b0, 32'h00500093, 1'b0});
      sb.push_back('{1'b1, 32'd17, 1'b0});
    end
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    wait_ack("cont.first", lat);
    check("cont.first.lat", lat, 32'd2);
    if (first_d) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
    wait_ack("cont.second", lat);
    check("cont.second.lat", lat, 32'd2);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // Range boundaries and undefined func3
    wc = write_cnt;
    d_op("st_oob", 1'b1, F3_WORD, 12'h3FE, 32'hDEADBEEF, 32'd0, 1'b1);
    check("st_oob.no_write", write_cnt - wc, 32'd0);
    check("st_oob.byte3fe", {24'd0, mem[10'h3FE]}, 32'hA5);
    check("st_oob.byte3ff", {24'd0, mem[10'h3FF]}, 32'h5A);
    d_op("lw_edge", 1'b0, F3_WORD, 12'h3FC, 32'd0, 32'h5AA52211, 1'b0);
    d_op("lbu_last", 1'b0, F3_BYTEU, 12'h3FF, 32'd0, 32'h0000005A, 1'b0);
    d_op("f3_bad", 1'b0, 3'b011, 12'h000, 32'd0, 32'd0, 1'b1);
    i_op("fetch_oob", 12'hFFC, 32'd0, 1'b1);

    // Reset while a store is in SERVE
    wc = write_cnt;
    bus.d_we    = 1'b1;
    bus.d_func3 = F3_BYTE;
    bus.d_addr  = 12'h200;
    bus.d_wdata = 32'h00000077;
    bus.d_req   = 1'b1;
    tick();
    check("pre_rst.mem_write", {31'd0, bus.mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_serve.mem_write", {31'd0, bus.mem_write}, 32'd0);
    tick();
    rst       = 1'b0;
    bus.d_req = 1'b0;
    check("rst_serve.byte200", {24'd0, mem[10'h200]}, 32'h33);
    check("rst_serve.no_write", write_cnt - wc, 32'd0);
    check("rst_serve.d_ack", {31'd0, bus.d_ack}, 32'd0);
    check("rst_serve.d_err", {31'd0, bus.d_err}, 32'd0);
    check("rst_serve.i_err", {31'd0, bus.i_err}, 32'd0);
    check("rst_serve.d_rdata", bus.d_rdata, 32'd0);
    check("rst_serve.i_rdata", bus.i_rdata, 32'd0);
    tick();
    check("rst_serve.d_ack_late", {31'd0, bus.d_ack}, 32'd0);
    d_op("post_rst", 1'b0, F3_BYTEU, 12'h200, 32'd0, 32'h33, 1'b0);

    // Both requesters held continuously: acks must alternate at one per two cycles
    bus.i_addr  = 12'h010;
    bus.d_we    = 1'b0;
    bus.d_func3 = F3_WORD;
    bus.d_addr  = 12'h3FC;
    for (int k = 0; k < 20; k++) begin
      if (((k % 2) == 0) == !RrEn) sb.push_back('{1'b1, 32'h5AA52211, 1'b0});
      else sb.push_back('{1'b0, 32'h00500093, 1'b0});
    end
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_ack($sformatf("alt%0d", k), lat);
      check($sformatf("alt%0d.lat", k), lat, 32'd2);
      if (k == 19) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    tick();
    tick();
    check("end.sb_empty", sb.size(), 32'd0);
    check("end.idle_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
